// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants for the Y86-64 fetch unit.
//   - icode values HALT..POPQ
//   - STAT codes AOK/HLT/ADR/INS
//   - default datapath width
//   - fetch FSM state type
package fetch_unit_pkg;

  localparam int DEFAULT_DATA_WID = 64;

  localparam logic [3:0] IC_HALT   = 4'h0;
  localparam logic [3:0] IC_NOP    = 4'h1;
  localparam logic [3:0] IC_RRMOVQ = 4'h2;
  localparam logic [3:0] IC_IRMOVQ = 4'h3;
  localparam logic [3:0] IC_RMMOVQ = 4'h4;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_OPQ    = 4'h6;
  localparam logic [3:0] IC_JXX    = 4'h7;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_REGS,
    S_CONST,
    S_DONE
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundle of the fetch unit's bus signals.
//   PC input handshake   : PC_IN, PC_VALID, PC_READY
//   instruction memory   : IMEM_REQ, IMEM_ADDR, IMEM_ACK, IMEM_DATA, IMEM_ERR
//   decoded output       : icode, ifun, rA, rB, valC, valP, STAT,
//                          OUT_VALID, OUT_READY
// master = the fetch unit, slave = its environment (PC stage, memory, decode).
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int DATA_WID = DEFAULT_DATA_WID
);
  logic [DATA_WID-1:0] PC_IN;
  logic                PC_VALID;
  logic                PC_READY;
  logic                IMEM_REQ;
  logic [DATA_WID-1:0] IMEM_ADDR;
  logic                IMEM_ACK;
  logic [7:0]          IMEM_DATA;
  logic                IMEM_ERR;
  logic [3:0]          icode;
  logic [3:0]          ifun;
  logic [3:0]          rA;
  logic [3:0]          rB;
  logic [DATA_WID-1:0] valC;
  logic [DATA_WID-1:0] valP;
  logic [1:0]          STAT;
  logic                OUT_VALID;
  logic                OUT_READY;

  modport master (
    input  PC_IN, PC_VALID, IMEM_ACK, IMEM_DATA, IMEM_ERR, OUT_READY,
    output PC_READY, IMEM_REQ, IMEM_ADDR, icode, ifun, rA, rB, valC, valP,
           STAT, OUT_VALID
  );

  modport slave (
    output PC_IN, PC_VALID, IMEM_ACK, IMEM_DATA, IMEM_ERR, OUT_READY,
    input  PC_READY, IMEM_REQ, IMEM_ADDR, icode, ifun, rA, rB, valC, valP,
           STAT, OUT_VALID
  );
endinterface

// File: rtl/fetch_unit_instr_len_decode.sv
// instr_len_decode: combinational Y86-64 opcode classifier.
//   icode_i, ifun_i : opcode byte nibbles
//   len_o           : instruction length in bytes (1 for illegal opcodes)
//   has_regs_o      : instruction carries a register byte
//   has_const_o     : instruction carries a CONST_BYTES-byte constant
//   illegal_o       : unknown icode or ifun out of range for the icode
module instr_len_decode
  import fetch_unit_pkg::*;
#(
  parameter int CONST_BYTES = 8,
  parameter int LW          = $clog2(CONST_BYTES + 3)
) (
  input  logic [3:0]    icode_i,
  input  logic [3:0]    ifun_i,
  output logic [LW-1:0] len_o,
  output logic          has_regs_o,
  output logic          has_const_o,
  output logic          illegal_o
);

  logic regs, cnst, legal;

  always_comb begin
    regs  = 1'b0;
    cnst  = 1'b0;
    legal = 1'b0;
    unique case (icode_i)
      IC_HALT, IC_NOP, IC_RET: legal = (ifun_i == 4'd0);
      IC_RRMOVQ: begin regs = 1'b1; legal = (ifun_i <= 4'd6); end
      IC_IRMOVQ, IC_RMMOVQ, IC_MRMOVQ: begin
        regs  = 1'b1;
        cnst  = 1'b1;
        legal = (ifun_i == 4'd0);
      end
      IC_OPQ:    begin regs = 1'b1; legal = (ifun_i <= 4'd3); end
      IC_JXX:    begin cnst = 1'b1; legal = (ifun_i <= 4'd6); end
      IC_CALL:   begin cnst = 1'b1; legal = (ifun_i == 4'd0); end
      IC_PUSHQ, IC_POPQ: begin regs = 1'b1; legal = (ifun_i == 4'd0); end
      default:   legal = 1'b0;
    endcase
  end

  // An illegal opcode is treated as a one-byte instruction.
  assign illegal_o   = ~legal;
  assign has_regs_o  = legal & regs;
  assign has_const_o = legal & cnst;
  assign len_o       = LW'(1) + LW'(has_regs_o) +
                       (has_const_o ? LW'(CONST_BYTES) : LW'(0));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential Y86-64 instruction fetch.
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   bus        : fetch_unit_if master
//     PC_IN/PC_VALID/PC_READY      - accept the next PC (only in IDLE)
//     IMEM_REQ/IMEM_ADDR/IMEM_ACK/IMEM_DATA/IMEM_ERR
//                                  - one byte per acked request at PC+k
//     icode/ifun/rA/rB/valC/valP/STAT, OUT_VALID/OUT_READY
//                                  - registered decoded instruction
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DATA_WID = DEFAULT_DATA_WID
) (
  input  logic         CLK,
  input  logic         RST_N,
  fetch_unit_if.master bus
);

  localparam int CB = DATA_WID / 8;
  localparam int KW = $clog2(CB + 3);

  fetch_state_t        state_q, state_d;
  logic [DATA_WID-1:0] pc_q, pc_d;
  logic [KW-1:0]       k_q, k_d;
  logic [KW-1:0]       len_q, len_d;
  logic                has_regs_q, has_regs_d;
  logic                has_const_q, has_const_d;
  logic [3:0]          icode_q, icode_d;
  logic [3:0]          ifun_q, ifun_d;
  logic [3:0]          ra_q, ra_d;
  logic [3:0]          rb_q, rb_d;
  logic [DATA_WID-1:0] valc_q, valc_d;
  logic [DATA_WID-1:0] valp_q, valp_d;
  logic [1:0]          stat_q, stat_d;

  logic [KW-1:0]       dec_len;
  logic                dec_regs, dec_const, dec_illegal;
  logic                req;
  logic [DATA_WID-1:0] cur_addr;
  logic [KW-1:0]       cidx;

  instr_len_decode #(
    .CONST_BYTES (CB),
    .LW          (KW)
  ) u_len (
    .icode_i     (bus.IMEM_DATA[7:4]),
    .ifun_i      (bus.IMEM_DATA[3:0]),
    .len_o       (dec_len),
    .has_regs_o  (dec_regs),
    .has_const_o (dec_const),
    .illegal_o   (dec_illegal)
  );

  assign req      = (state_q == S_OPC) || (state_q == S_REGS) || (state_q == S_CONST);
  // PC+k is also the fault valP: the number of bytes acked before the fault.
  assign cur_addr = pc_q + DATA_WID'(k_q);
  // Constant byte index: k minus the opcode byte and optional register byte.
  assign cidx     = k_q - (has_regs_q ? KW'(2) : KW'(1));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    k_d         = k_q;
    len_d       = len_q;
    has_regs_d  = has_regs_q;
    has_const_d = has_const_q;
    icode_d     = icode_q;
    ifun_d      = ifun_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    valc_d      = valc_q;
    valp_d      = valp_q;
    stat_d      = stat_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.PC_VALID) begin
          pc_d    = bus.PC_IN;
          k_d     = '0;
          icode_d = 4'h0;
          ifun_d  = 4'h0;
          ra_d    = REG_NONE;
          rb_d    = REG_NONE;
          valc_d  = '0;
          valp_d  = '0;
          stat_d  = STAT_AOK;
          state_d = S_OPC;
        end
      end

      S_OPC: begin
        if (bus.IMEM_ACK) begin
          if (bus.IMEM_ERR) begin
            stat_d  = STAT_ADR;
            valp_d  = cur_addr;
            state_d = S_DONE;
          end else begin
            icode_d     = bus.IMEM_DATA[7:4];
            ifun_d      = bus.IMEM_DATA[3:0];
            k_d         = k_q + KW'(1);
            len_d       = dec_len;
            has_regs_d  = dec_regs;
            has_const_d = dec_const;
            if (dec_illegal) begin
              stat_d  = STAT_INS;
              valp_d  = pc_q + DATA_WID'(dec_len);
              state_d = S_DONE;
            end else if (bus.IMEM_DATA[7:4] == IC_HALT) begin
              stat_d  = STAT_HLT;
              valp_d  = pc_q + DATA_WID'(dec_len);
              state_d = S_DONE;
            end else if (dec_regs) begin
              state_d = S_REGS;
            end else if (dec_const) begin
              state_d = S_CONST;
            end else begin
              valp_d  = pc_q + DATA_WID'(dec_len);
              state_d = S_DONE;
            end
          end
        end
      end

      S_REGS: begin
        if (bus.IMEM_ACK) begin
          if (bus.IMEM_ERR) begin
            stat_d  = STAT_ADR;
            valp_d  = cur_addr;
            state_d = S_DONE;
          end else begin
            ra_d = bus.IMEM_DATA[7:4];
            rb_d = bus.IMEM_DATA[3:0];
            k_d  = k_q + KW'(1);
            if (has_const_q) begin
              state_d = S_CONST;
            end else begin
              valp_d  = pc_q + DATA_WID'(len_q);
              state_d = S_DONE;
            end
          end
        end
      end

      S_CONST: begin
        if (bus.IMEM_ACK) begin
          if (bus.IMEM_ERR) begin
            stat_d  = STAT_ADR;
            valp_d  = cur_addr;
            state_d = S_DONE;
          end else begin
            valc_d[8*int'(cidx) +: 8] = bus.IMEM_DATA;
            k_d = k_q + KW'(1);
            if (k_q + KW'(1) == len_q) begin
              valp_d  = pc_q + DATA_WID'(len_q);
              state_d = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        if (bus.OUT_READY) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      k_q         <= '0;
      len_q       <= '0;
      has_regs_q  <= 1'b0;
      has_const_q <= 1'b0;
      icode_q     <= 4'h0;
      ifun_q      <= 4'h0;
      ra_q        <= REG_NONE;
      rb_q        <= REG_NONE;
      valc_q      <= '0;
      valp_q      <= '0;
      stat_q      <= STAT_AOK;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      k_q         <= k_d;
      len_q       <= len_d;
      has_regs_q  <= has_regs_d;
      has_const_q <= has_const_d;
      icode_q     <= icode_d;
      ifun_q      <= ifun_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      valc_q      <= valc_d;
      valp_q      <= valp_d;
      stat_q      <= stat_d;
    end
  end

  assign bus.PC_READY  = (state_q == S_IDLE);
  assign bus.IMEM_REQ  = req;
  assign bus.IMEM_ADDR = req ? cur_addr : '0;
  assign bus.OUT_VALID = (state_q == S_DONE);
  assign bus.icode     = icode_q;
  assign bus.ifun      = ifun_q;
  assign bus.rA        = ra_q;
  assign bus.rB        = rb_q;
  assign bus.valC      = valc_q;
  assign bus.valP      = valp_q;
  assign bus.STAT      = stat_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.DATA_WID(64)) bus ();

  fetch_unit #(.DATA_WID(64)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [79:0] bytes;   // byte i of the instruction in bits [8i+7:8i]
    int          wt;      // memory wait cycles per byte
    int          err;     // byte index that faults, -1 for none
    int          hold;    // cycles OUT_READY is held low after OUT_VALID
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [1:0]  stat;
    int          acks;
  } vec_t;

  vec_t vecs [14];

  int errors = 0;
  int checks = 0;
  int cur_vec = -1;

  // memory model state
  logic [63:0] mem_base = '0;
  logic [79:0] mem_bytes = '0;
  int          mem_wait = 0;
  int          err_idx = -1;
  int          ack_cnt = 0;
  int          wcnt = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL vec=%0d %s: got=%h expected=%h", cur_vec, name, got, exp);
    end
  endtask

  // Byte-wide memory: responds on the falling edge so the DUT samples on the next rising edge.
  always @(negedge clk) begin
    logic [63:0] off;
    int o;
    if (!rst_n || !bus.IMEM_REQ) begin
      bus.IMEM_ACK  = 1'b0;
      bus.IMEM_ERR  = 1'b0;
      bus.IMEM_DATA = 8'h00;
      wcnt = 0;
    end else if (wcnt >= mem_wait) begin
      off = bus.IMEM_ADDR - mem_base;
      o = (off < 64'd10) ? int'(off[3:0]) : -1;
      bus.IMEM_ACK  = 1'b1;
      bus.IMEM_DATA = (o >= 0) ? mem_bytes[8*o +: 8] : 8'h00;
      bus.IMEM_ERR  = (err_idx >= 0) && (o == err_idx);
      ack_cnt++;
      wcnt = 0;
    end else begin
      bus.IMEM_ACK = 1'b0;
      bus.IMEM_ERR = 1'b0;
      wcnt++;
    end
  end

  task automatic load_mem(input vec_t v);
    mem_base  = v.pc;
    mem_bytes = v.bytes;
    mem_wait  = v.wt;
    err_idx   = v.err;
    ack_cnt   = 0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int n;
    int lat;
    v = vecs[idx];
    cur_vec = idx;
    load_mem(v);
    n = 0;
    while (!bus.PC_READY && n < 100) begin @(posedge clk); #1; n++; end
    chk("pc_ready_before", {63'd0, bus.PC_READY}, 64'd1);
    bus.PC_IN = v.pc;
    bus.PC_VALID = 1'b1;
    @(posedge clk); #1;
    bus.PC_VALID = 1'b0;
    lat = 0;
    while (!bus.OUT_VALID && lat < 500) begin @(posedge clk); #1; lat++; end
    chk("out_valid", {63'd0, bus.OUT_VALID}, 64'd1);
    chk("latency", 64'(lat), 64'(v.acks * (v.wt + 1)));
    chk("icode", {60'd0, bus.icode}, {60'd0, v.icode});
    chk("ifun",  {60'd0, bus.ifun},  {60'd0, v.ifun});
    chk("rA",    {60'd0, bus.rA},    {60'd0, v.ra});
    chk("rB",    {60'd0, bus.rB},    {60'd0, v.rb});
    chk("valC",  bus.valC, v.valc);
    chk("valP",  bus.valP, v.valp);
    chk("STAT",  {62'd0, bus.STAT},  {62'd0, v.stat});
    chk("acks",  64'(ack_cnt), 64'(v.acks));
    // Backpressure: a new PC is offered but must not be taken, outputs frozen.
    for (int c = 0; c < v.hold; c++) begin
      bus.PC_IN = 64'hDEAD;
      bus.PC_VALID = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, bus.OUT_VALID}, 64'd1);
      chk("hold_pc_ready", {63'd0, bus.PC_READY}, 64'd0);
      chk("hold_req", {63'd0, bus.IMEM_REQ}, 64'd0);
      chk("hold_fields", {bus.icode, bus.ifun, bus.rA, bus.rB, 46'd0, bus.STAT},
          {v.icode, v.ifun, v.ra, v.rb, 46'd0, v.stat});
      chk("hold_valP", bus.valP, v.valp);
    end
    bus.PC_VALID = 1'b0;
    bus.OUT_READY = 1'b1;
    @(posedge clk); #1;
    bus.OUT_READY = 1'b0;
    chk("after_hs_valid", {63'd0, bus.OUT_VALID}, 64'd0);
    chk("after_hs_ready", {63'd0, bus.PC_READY}, 64'd1);
  endtask

  initial begin
    //          pc                       bytes                      wt err hold icode ifun ra    rb    valc                   valp                   stat      acks
    vecs[0]  = '{64'h100, 80'h0000000000000008F230, 0, -1, 0, 4'h3, 4'h0, 4'hF, 4'h2, 64'h8, 64'h10A, STAT_AOK, 10};
    vecs[1]  = '{64'h20,  80'h90,                   0, -1, 0, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21,  STAT_AOK, 1};
    vecs[2]  = '{64'h20,  80'h00000000000000004080, 0, -1, 0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 64'h29, STAT_AOK, 9};
    vecs[3]  = '{64'h40,  80'h2360,                 3, -1, 5, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h42,  STAT_AOK, 2};
    vecs[4]  = '{64'h300, 80'hE0,                   0, -1, 0, 4'hE, 4'h0, 4'hF, 4'hF, 64'h0, 64'h301, STAT_INS, 1};
    vecs[5]  = '{64'h310, 80'h64,                   0, -1, 0, 4'h6, 4'h4, 4'hF, 4'hF, 64'h0, 64'h311, STAT_INS, 1};
    vecs[6]  = '{64'h400, 80'h1250,                 0,  3, 0, 4'h5, 4'h0, 4'h1, 4'h2, 64'h0, 64'h403, STAT_ADR, 4};
    vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h10,   0, -1, 0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0,   STAT_AOK, 1};
    vecs[8]  = '{64'h500, 80'h00,                   0, -1, 0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h501, STAT_HLT, 1};
    vecs[9]  = '{64'h600, 80'h00112233445566778874, 0, -1, 0, 4'h7, 4'h4, 4'hF, 4'hF, 64'h1122334455667788, 64'h609, STAT_AOK, 9};
    vecs[10] = '{64'h610, 80'hAB25,                 1, -1, 0, 4'h2, 4'h5, 4'hA, 4'hB, 64'h0, 64'h612, STAT_AOK, 2};
    vecs[11] = '{64'h700, 80'h10,                   0,  0, 0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h700, STAT_ADR, 1};
    vecs[12] = '{64'h710, 80'h3FA0,                 0, -1, 0, 4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'h712, STAT_AOK, 2};
    vecs[13] = '{64'h720, 80'h4563,                 2, -1, 0, 4'h6, 4'h3, 4'h4, 4'h5, 64'h0, 64'h722, STAT_AOK, 2};

    bus.PC_IN = '0;
    bus.PC_VALID = 1'b0;
    bus.OUT_READY = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   {63'd0, bus.IMEM_REQ}, 64'd0);
    chk("rst_valid", {63'd0, bus.OUT_VALID}, 64'd0);
    chk("rst_stat",  {62'd0, bus.STAT}, 64'd0);
    chk("rst_fields", {48'd0, bus.icode, bus.ifun, bus.rA, bus.rB}, 64'h00FF);
    chk("rst_valC",  bus.valC, 64'd0);
    chk("rst_valP",  bus.valP, 64'd0);
    chk("rst_addr",  bus.IMEM_ADDR, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_pc_ready", {63'd0, bus.PC_READY}, 64'd1);

    for (int i = 0; i < 14; i++) run_vec(i);

    // Reset in the middle of the constant of an irmovq.
    begin
      vec_t v;
      int n;
      cur_vec = 100;
      v = vecs[0];
      v.wt = 1;
      load_mem(v);
      bus.PC_IN = v.pc;
      bus.PC_VALID = 1'b1;
      @(posedge clk); #1;
      bus.PC_VALID = 1'b0;
      n = 0;
      while (!(ack_cnt >= 4 && bus.IMEM_REQ) && n < 200) begin @(posedge clk); #1; n++; end
      chk("mid_reached", {63'd0, bus.IMEM_REQ}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_req",   {63'd0, bus.IMEM_REQ}, 64'd0);
      chk("mid_valid", {63'd0, bus.OUT_VALID}, 64'd0);
      chk("mid_icode", {60'd0, bus.icode}, 64'd0);
      chk("mid_rA",    {60'd0, bus.rA}, 64'hF);
      chk("mid_valC",  bus.valC, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid_pc_ready", {63'd0, bus.PC_READY}, 64'd1);
      chk("mid_no_req",   {63'd0, bus.IMEM_REQ}, 64'd0);
      run_vec(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
